// File: rtl/byte_deframe_if.sv
// Symbol-in / packet-out bundle for byte_deframe.
// Optional PKT_LEN field present when BYTE_DEFRAME_LEN_EN is defined.
interface byte_deframe_if #(
  parameter int unsigned BITS = 8
);
  logic [BITS-1:0] d;
  logic            dk;
  logic [BITS-1:0] data_out;
  logic            valid;
  logic            sop;
  logic            eop;
  logic            err;
  logic            pkt_tlp;
`ifdef BYTE_DEFRAME_LEN_EN
  logic [15:0]     pkt_len;
`endif

  // Deframer side: consumes symbols, produces payload bytes
  modport master (
    input  d, dk,
    output data_out, valid, sop, eop, err, pkt_tlp
`ifdef BYTE_DEFRAME_LEN_EN
    , output pkt_len
`endif
  );

  // Stream side: drives symbols, observes payload bytes
  modport slave (
    output d, dk,
    input  data_out, valid, sop, eop, err, pkt_tlp
`ifdef BYTE_DEFRAME_LEN_EN
    , input pkt_len
`endif
  );
endinterface

// File: rtl/byte_deframe.sv
// Recovers STP/SDP packets from a D/DK symbol stream: strips framing and ordered
// sets, emits payload bytes with SOP/EOP/ERR through a one-byte holding register.
// Optional feature macro: BYTE_DEFRAME_LEN_EN adds the PKT_LEN output.
module byte_deframe #(
  parameter int unsigned BITS    = 8,
  parameter int unsigned MAX_LEN = 1024
) (
  input logic          clk,
  input logic          rst,
  byte_deframe_if.master bus
);
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_EDB = 8'hFE;

  typedef enum logic [1:0] {IDLE, IN_PKT, DRAIN} state_t;

  state_t          state;
  logic [BITS-1:0] hold;
  logic            hold_full;
  logic [CW-1:0]   count;
  logic            first;
  logic            cur_tlp;

  logic [7:0]      sym;
  logic            is_start_c;
  logic            term_c;
  logic            term_err_c;

  assign sym        = bus.d[7:0];
  assign is_start_c = bus.dk && ((sym == K_STP) || (sym == K_SDP));

  // Decide whether this symbol closes the current packet, and whether as an error
  always_comb begin
    term_c     = 1'b0;
    term_err_c = 1'b1;
    if (state == IN_PKT) begin
      if (!bus.dk) begin
        term_c = (count == CW'(MAX_LEN));
      end else begin
        term_c     = (sym != K_COM) && (sym != K_SKP);
        term_err_c = (sym != K_END);
      end
    end
  end

  // Framing FSM, holding register and registered output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold         <= '0;
      hold_full    <= 1'b0;
      count        <= '0;
      first        <= 1'b0;
      cur_tlp      <= 1'b0;
      bus.data_out <= '0;
      bus.valid    <= 1'b0;
      bus.sop      <= 1'b0;
      bus.eop      <= 1'b0;
      bus.err      <= 1'b0;
      bus.pkt_tlp  <= 1'b0;
`ifdef BYTE_DEFRAME_LEN_EN
      bus.pkt_len  <= '0;
`endif
    end else begin
      bus.valid   <= 1'b0;
      bus.sop     <= 1'b0;
      bus.eop     <= 1'b0;
      bus.err     <= 1'b0;
      // Type output follows the live packet, but lags one edge on an abort-restart
      bus.pkt_tlp <= cur_tlp;

      if (term_c) begin
        if (hold_full) begin
          bus.valid    <= 1'b1;
          bus.data_out <= hold;
          bus.sop      <= first;
          bus.eop      <= 1'b1;
          bus.err      <= term_err_c;
`ifdef BYTE_DEFRAME_LEN_EN
          bus.pkt_len  <= 16'(count);
`endif
        end else begin
          bus.err <= 1'b1;
        end
        hold_full <= 1'b0;
      end

      case (state)
        IDLE, DRAIN: begin
          if (is_start_c) begin
            state       <= IN_PKT;
            cur_tlp     <= (sym == K_STP);
            bus.pkt_tlp <= (sym == K_STP);
            count       <= '0;
            first       <= 1'b1;
            hold_full   <= 1'b0;
          end else if ((state == DRAIN) && bus.dk &&
                       ((sym == K_END) || (sym == K_EDB))) begin
            state <= IDLE;
          end
        end
        IN_PKT: begin
          if (!bus.dk) begin
            if (term_c) begin
              state <= DRAIN;
            end else begin
              if (hold_full) begin
                bus.valid    <= 1'b1;
                bus.data_out <= hold;
                bus.sop      <= first;
                first        <= 1'b0;
              end
              hold      <= bus.d;
              hold_full <= 1'b1;
              count     <= count + CW'(1);
            end
          end else if (is_start_c) begin
            cur_tlp <= (sym == K_STP);
            count   <= '0;
            first   <= 1'b1;
          end else if (term_c) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
